// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
package lcd_pkg;

  localparam int unsigned CNT_W    = 24;
  localparam int unsigned INIT_LEN = 4;

  localparam int unsigned ON_BIT = 31;
  localparam int unsigned EN_BIT = 10;
  localparam int unsigned RS_BIT = 9;
  localparam int unsigned RW_BIT = 8;

  localparam logic [7:0] CMD_CLR  = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;

  // Entry 0 is the first command sent after power-up.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  typedef enum logic [2:0] {
    S_PWRUP,
    S_LOAD,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } lcd_state_e;

  // Down-counter load value for a state lasting n cycles; 0 is stretched to 1.
  function automatic logic [CNT_W-1:0] cyc_to_load(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d == CMD_CLR) || (d == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that saturates at zero and flags it.
module lcd_timer
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Character LCD write controller: power-up wait, fixed init sequence, then
// single-byte command/data transfers with EN timing and post-write waits.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned HOLD_CYC     = 4,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  output logic        o_init_done,
  output logic        o_busy,
  output logic [31:0] o_io_lcd
);

  localparam logic [CNT_W-1:0] LD_PWRUP = cyc_to_load(PWRUP_CYC);
  localparam logic [CNT_W-1:0] LD_SETUP = cyc_to_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] LD_EN    = cyc_to_load(EN_CYC);
  localparam logic [CNT_W-1:0] LD_HOLD  = cyc_to_load(HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_CMD   = cyc_to_load(CMD_WAIT_CYC);
  localparam logic [CNT_W-1:0] LD_CLR   = cyc_to_load(CLR_WAIT_CYC);

  lcd_state_e       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic [31:0]      io_lcd_q, io_lcd_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  lcd_timer #(
    .RST_VAL (LD_PWRUP)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_zero_c   (tmr_zero)
  );

  assign o_req_ready = (state_q == S_IDLE) && init_done_q;

  // Next state, timer reloads on every state change, and the pin word that
  // will be visible while the next state is current.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      S_PWRUP: begin
        if (tmr_zero) begin
          state_d = S_LOAD;
          idx_d   = 2'd0;
        end
      end
      S_LOAD: begin
        rs_d     = 1'b0;
        data_d   = INIT_ROM[idx_q];
        state_d  = S_SETUP;
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
      S_SETUP: begin
        if (tmr_zero) begin
          state_d  = S_EN_HI;
          tmr_load = 1'b1;
          tmr_val  = LD_EN;
        end
      end
      S_EN_HI: begin
        if (tmr_zero) begin
          state_d  = S_HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (tmr_zero) begin
          state_d  = S_WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
        end
      end
      S_WAIT: begin
        if (tmr_zero) begin
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 2'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_IDLE: begin
        if (i_req_valid && o_req_ready) begin
          rs_d     = i_req_rs;
          data_d   = i_req_data;
          state_d  = S_SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    busy_d           = (state_d != S_IDLE);
    io_lcd_d         = '0;
    io_lcd_d[ON_BIT] = 1'b1;
    io_lcd_d[EN_BIT] = (state_d == S_EN_HI);
    io_lcd_d[RS_BIT] = rs_d;
    io_lcd_d[RW_BIT] = 1'b0;
    io_lcd_d[7:0]    = data_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_PWRUP;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b1;
      io_lcd_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      io_lcd_q    <= io_lcd_d;
    end
  end

  assign o_init_done = init_done_q;
  assign o_busy      = busy_q;
  assign o_io_lcd    = io_lcd_q;

endmodule
